// File: rtl/parser_act_table_if.sv
// AXI-Stream bundle (no tready) for the parser control chain.
// The master side drives the beat and the slave side receives it.
interface parser_act_table_if #(
    parameter int DW = 512,
    parameter int TW = 128
);
    logic [DW-1:0]   tdata;
    logic [TW-1:0]   tuser;
    logic [DW/8-1:0] tkeep;
    logic            tvalid;
    logic            tlast;

    modport master (output tdata, tuser, tkeep, tvalid, tlast);
    modport slave  (input  tdata, tuser, tkeep, tvalid, tlast);
endinterface

// File: rtl/parser_act_table.sv
// Parser action table: absorbs its own configuration packets from the control
// stream, forwards all other traffic, and serves registered lookups with bypass.
module parser_act_table #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [2:0]  PARSER_MOD_ID        = 3'b0,
    parameter logic [15:0] C_CTRL_FLAG          = 16'hf2f1,
    parameter int          C_ENTRY_WIDTH        = 160,
    parameter int          C_TABLE_DEPTH        = 32,
    parameter int          C_VLANID_WIDTH       = 12,
    parameter int          C_IDX_LSB            = 4
) (
    input  logic                      axis_clk,
    input  logic                      aresetn,
    parser_act_table_if.slave         ctrl_s_axis,
    parser_act_table_if.master        ctrl_m_axis,
    input  logic [C_VLANID_WIDTH-1:0] s_vlan_id,
    input  logic                      s_vlan_id_valid,
    output logic [C_ENTRY_WIDTH-1:0]  lkp_entry,
    output logic                      lkp_hit,
    output logic                      lkp_valid,
    output logic [15:0]               wr_count
);
    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int TW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = C_ENTRY_WIDTH;
    localparam int NB    = DW / 8;
    localparam int IDX_W = $clog2(C_TABLE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_NEXT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               in_fwd;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [EW-1:0]      wr_data;
    logic [C_TABLE_DEPTH-1:0] valid;
    logic [EW-1:0]      mem [C_TABLE_DEPTH];

    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [EW-1:0]      rd_data;
    logic               rd_hit;

    logic [DW-1:0]      swapped;
    logic [EW-1:0]      entry;
    logic [TW-1:0]      s_user;
    logic               hdr_match;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   beat_idx;
    logic [IDX_W-1:0]   key_idx;
    logic               same_cycle;
    logic               out_bypass;
    logic               unused_bits;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        swapped = '0;
        for (int i = 0; i < NB; i++) begin
            swapped[(NB-1-i)*8 +: 8] = ctrl_s_axis.tdata[i*8 +: 8];
        end
    end

    assign entry     = swapped[DW-1 -: EW];
    assign s_user    = ctrl_s_axis.tuser;
    assign start_idx = ctrl_s_axis.tdata[384 +: IDX_W];
    assign hdr_match = ctrl_s_axis.tvalid && !in_fwd
                    && (ctrl_s_axis.tdata[368 +: 3] == PARSER_MOD_ID)
                    && (ctrl_s_axis.tdata[335:320] == C_CTRL_FLAG);
    assign beat_idx  = (state == S_NEXT) ? idx + IDX_W'(1) : idx;

    assign key_idx    = s_vlan_id[C_IDX_LSB +: IDX_W];
    assign same_cycle = wr_en && (wr_idx == key_idx);
    assign out_bypass = wr_en && (wr_idx == rd_idx);

    assign unused_bits = ^{s_vlan_id, swapped};

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= S_IDLE;
            idx                <= '0;
            in_fwd             <= 1'b0;
            wr_en              <= 1'b0;
            wr_idx             <= '0;
            wr_data            <= '0;
            ctrl_m_axis.tdata  <= '0;
            ctrl_m_axis.tuser  <= '0;
            ctrl_m_axis.tkeep  <= '0;
            ctrl_m_axis.tvalid <= 1'b0;
            ctrl_m_axis.tlast  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hdr_match) begin
                        idx                <= start_idx;
                        ctrl_m_axis.tvalid <= 1'b0;
                        ctrl_m_axis.tlast  <= 1'b0;
                        if (!ctrl_s_axis.tlast) state <= S_FIRST;
                    end else begin
                        ctrl_m_axis.tdata  <= ctrl_s_axis.tdata;
                        ctrl_m_axis.tuser  <= s_user;
                        ctrl_m_axis.tkeep  <= ctrl_s_axis.tkeep;
                        ctrl_m_axis.tvalid <= ctrl_s_axis.tvalid;
                        ctrl_m_axis.tlast  <= ctrl_s_axis.tlast;
                        if (ctrl_s_axis.tvalid) in_fwd <= !ctrl_s_axis.tlast;
                    end
                end
                S_FIRST, S_NEXT: begin
                    ctrl_m_axis.tvalid <= 1'b0;
                    ctrl_m_axis.tlast  <= 1'b0;
                    if (ctrl_s_axis.tvalid) begin
                        idx     <= beat_idx;
                        wr_en   <= 1'b1;
                        wr_idx  <= beat_idx;
                        wr_data <= entry;
                        state   <= ctrl_s_axis.tlast ? S_IDLE : S_NEXT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Commit stage: valid bits and the write counter follow the pipelined write.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            valid    <= '0;
            wr_count <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end

    // NOTE: the array has no reset; stale words are masked by the valid bits instead.
    always_ff @(posedge axis_clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
        rd_data <= same_cycle ? wr_data : mem[key_idx];
    end

    // A write committing on the read edge is caught here, one committing an edge later at the output.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            rd_en     <= 1'b0;
            rd_idx    <= '0;
            rd_hit    <= 1'b0;
            lkp_entry <= '0;
            lkp_hit   <= 1'b0;
            lkp_valid <= 1'b0;
        end else begin
            rd_en     <= s_vlan_id_valid;
            rd_idx    <= key_idx;
            rd_hit    <= valid[key_idx] | same_cycle;
            lkp_valid <= rd_en;
            if (rd_en) begin
                lkp_entry <= out_bypass ? wr_data : rd_data;
                lkp_hit   <= rd_hit | out_bypass;
            end
        end
    end
endmodule
